// File: rtl/perisph_bus_ctrl.sv
// Memory-mapped peripheral bus controller: decodes a contiguous channel window and
// runs one ready-paced access per request, flagging a timeout with err.

module perisph_bus_lane #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic [DATA_W-1:0] rdata_g
);
  assign hit     = sel & ready;
  assign rdata_g = sel ? rdata : '0;
endmodule

module perisph_bus_ctrl #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int          NCH     = 8,
  parameter int unsigned BASE    = 'hF0,
  parameter int          TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  mem_io,
  output logic [NCH-1:0]        ch_en,
  output logic                  ch_we,
  output logic [DATA_W-1:0]     ch_wdata,
  input  logic [NCH*DATA_W-1:0] ch_rdata,
  input  logic [NCH-1:0]        ch_ready
);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  BASE_X = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0]  NCH_X  = (ADDR_W+1)'(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [NCH-1:0]    ch_en_d, dec;
  logic              ch_we_d, ack_d, err_d;
  logic [DATA_W-1:0] ch_wdata_d, rdata_d, sel_rd;
  logic [ADDR_W:0]   off;
  logic [IDX_W-1:0]  idx;
  logic              sel_ready;

  logic [NCH-1:0]             lane_hit;
  logic [NCH-1:0][DATA_W-1:0] lane_rd;

  // The extra top bit of off catches addresses below BASE.
  assign off    = {1'b0, addr} - BASE_X;
  assign mem_io = ({1'b0, addr} >= BASE_X) && (off < NCH_X);
  assign idx    = off[IDX_W-1:0];

  // Each lane only answers while its ch_en bit is set, so stray readies are masked.
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    perisph_bus_lane #(.DATA_W(DATA_W)) u_lane (
      .sel     (ch_en[i]),
      .ready   (ch_ready[i]),
      .rdata   (ch_rdata[i*DATA_W +: DATA_W]),
      .hit     (lane_hit[i]),
      .rdata_g (lane_rd[i])
    );
  end

  always_comb begin
    sel_rd = '0;
    dec    = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_rd |= lane_rd[i];
      dec[i]  = (idx == IDX_W'(i));
    end
    sel_ready = |lane_hit;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ch_en_d    = ch_en;
    ch_we_d    = ch_we;
    ch_wdata_d = ch_wdata;
    rdata_d    = rdata;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state)
      IDLE: if ((we | re) && mem_io) begin
        state_d    = ACCESS;
        ch_en_d    = dec;
        ch_we_d    = we;
        ch_wdata_d = wdata;
        cnt_d      = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d = DONE;
          ack_d   = 1'b1;
          ch_en_d = '0;
          ch_we_d = 1'b0;
          if (!ch_we) rdata_d = sel_rd;
        end else if (cnt == CNT_MAX) begin
          state_d = DONE;
          err_d   = 1'b1;
          ch_en_d = '0;
          ch_we_d = 1'b0;
          if (!ch_we) rdata_d = '1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ch_en    <= '0;
      ch_we    <= 1'b0;
      ch_wdata <= '0;
      rdata    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ch_en    <= ch_en_d;
      ch_we    <= ch_we_d;
      ch_wdata <= ch_wdata_d;
      rdata    <= rdata_d;
      ack      <= ack_d;
      err      <= err_d;
    end
  end
endmodule
